// File: rtl/bus_pkg.sv
// Shared types and default constants for the system bus and its DMA engine.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_e;

    // Region -> slave map, entry 0 rightmost, 2 bits per entry: {2,2,2,2,2,2,1,0}
    localparam logic [15:0] C_region_map_default  = 16'hAAA4;
    localparam logic [15:0] C_dma_trigger_default = 16'h4014;
    localparam logic [15:0] C_dma_target_default  = 16'h2004;
    localparam int unsigned C_dma_length_default  = 256;

    // Index width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/bus_mux.sv
// Selects one slave's read data; zero when the selection is not a real slave.
module bus_mux #(
    parameter int unsigned P_width     = 8,
    parameter int unsigned P_count     = 3,
    parameter int unsigned P_sel_width = 2
) (
    input  logic [P_width-1:0]     data [P_count],
    input  logic [P_sel_width-1:0] sel,
    input  logic                   valid,
    output logic [P_width-1:0]     out_c
);

    // Compare-and-pick avoids indexing past the array end
    always_comb begin
        out_c = '0;
        for (int i = 0; i < int'(P_count); i++) begin
            if (valid && (sel == P_sel_width'(i))) begin
                out_c = data[i];
            end
        end
    end

endmodule

// File: rtl/region_decode.sv
// Maps the top address bits to a slave index and a one-hot strobe mask.
module region_decode
    import bus_pkg::*;
#(
    parameter int unsigned P_addr_width   = 16,
    parameter int unsigned P_select_width = 3,
    parameter int unsigned P_slaves       = 3,
    parameter int unsigned P_idx_width    = 2,
    parameter logic [(2**P_select_width)*P_idx_width-1:0] P_region_map = C_region_map_default
) (
    input  logic [P_addr_width-1:0] addr,
    output logic [P_idx_width-1:0]  slave_c,
    output logic                    valid_c,
    output logic [P_slaves-1:0]     onehot_c
);

    logic [P_select_width-1:0] region;

    // Table lookup; indices past the last slave decode to nothing
    always_comb begin
        region   = addr[P_addr_width-1 -: P_select_width];
        slave_c  = P_region_map[32'(region) * P_idx_width +: P_idx_width];
        valid_c  = (32'(slave_c) < P_slaves);
        onehot_c = '0;
        for (int i = 0; i < int'(P_slaves); i++) begin
            if (valid_c && (slave_c == P_idx_width'(i))) begin
                onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_bus.sv
// Host-to-slave address decoder with a page-copy DMA engine that steals the bus.
module system_bus
    import bus_pkg::*;
#(
    parameter int unsigned P_addr_width   = 16,
    parameter int unsigned P_data_width   = 8,
    parameter int unsigned P_select_width = 3,
    parameter int unsigned P_slaves       = 3,
    parameter logic [(2**P_select_width)*clog2_min1(P_slaves)-1:0] P_region_map = C_region_map_default,
    parameter logic [P_addr_width-1:0] P_dma_trigger = C_dma_trigger_default,
    parameter logic [P_addr_width-1:0] P_dma_target  = C_dma_target_default,
    parameter int unsigned P_dma_length   = C_dma_length_default
) (
    input  logic                    I_clock,
    input  logic                    I_reset,
    input  logic                    I_tick,
    input  logic [P_addr_width-1:0] I_host_addr,
    input  logic                    I_host_wren,
    input  logic                    I_host_rden,
    input  logic [P_data_width-1:0] I_host_data,
    output logic [P_data_width-1:0] O_host_data,
    output logic                    O_host_ready,
    output logic [P_addr_width-1:0] O_bus_addr,
    output logic [P_data_width-1:0] O_bus_data,
    output logic [P_slaves-1:0]     O_bus_wren,
    output logic [P_slaves-1:0]     O_bus_rden,
    input  logic [P_data_width-1:0] I_bus_data [P_slaves],
    output logic                    O_dma_busy
);

    localparam int unsigned L_idx_w = clog2_min1(P_slaves);
    localparam int unsigned L_cnt_w = clog2_min1(P_dma_length);
    localparam logic [L_cnt_w-1:0] L_cnt_last = L_cnt_w'(P_dma_length - 1);

    dma_state_e              state;
    logic [P_data_width-1:0] page;
    logic [P_data_width-1:0] data_q;
    logic [L_cnt_w-1:0]      count;

    logic [P_addr_width-1:0] dma_addr_c;
    logic [L_idx_w-1:0]      host_idx, dma_idx, sel_idx;
    logic                    host_valid, dma_valid, sel_valid;
    logic [P_slaves-1:0]     host_onehot, dma_onehot;
    logic                    trigger_wr_c;

    region_decode #(
        .P_addr_width  (P_addr_width),
        .P_select_width(P_select_width),
        .P_slaves      (P_slaves),
        .P_idx_width   (L_idx_w),
        .P_region_map  (P_region_map)
    ) u_host_decode (
        .addr    (I_host_addr),
        .slave_c (host_idx),
        .valid_c (host_valid),
        .onehot_c(host_onehot)
    );

    region_decode #(
        .P_addr_width  (P_addr_width),
        .P_select_width(P_select_width),
        .P_slaves      (P_slaves),
        .P_idx_width   (L_idx_w),
        .P_region_map  (P_region_map)
    ) u_dma_decode (
        .addr    (dma_addr_c),
        .slave_c (dma_idx),
        .valid_c (dma_valid),
        .onehot_c(dma_onehot)
    );

    bus_mux #(
        .P_width    (P_data_width),
        .P_count    (P_slaves),
        .P_sel_width(L_idx_w)
    ) u_read_mux (
        .data (I_bus_data),
        .sel  (sel_idx),
        .valid(sel_valid),
        .out_c(O_host_data)
    );

    // DMA address: target during WRITE, otherwise {page, count}
    always_comb begin
        dma_addr_c   = P_addr_width'({page, 8'(count)});
        if (state == ST_WRITE) begin
            dma_addr_c = P_dma_target;
        end
        sel_idx      = O_dma_busy ? dma_idx : host_idx;
        sel_valid    = O_dma_busy ? dma_valid : host_valid;
        trigger_wr_c = I_host_wren && (I_host_addr == P_dma_trigger) && !O_dma_busy;
    end

    // Bus ownership: host pass-through when idle, DMA strobes only on ticks
    always_comb begin
        O_bus_addr = I_host_addr;
        O_bus_data = I_host_data;
        O_bus_wren = '0;
        O_bus_rden = '0;
        if (!O_dma_busy) begin
            if (I_host_wren) O_bus_wren = host_onehot;
            if (I_host_rden) O_bus_rden = host_onehot;
        end else begin
            O_bus_addr = dma_addr_c;
            O_bus_data = data_q;
            if (I_tick && (state == ST_READ))  O_bus_rden = dma_onehot;
            if (I_tick && (state == ST_WRITE)) O_bus_wren = dma_onehot;
        end
    end

    // DMA sequencer with registered ready/busy
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            page         <= '0;
            data_q       <= '0;
            O_host_ready <= 1'b1;
            O_dma_busy   <= 1'b0;
        end else begin
            if (trigger_wr_c) begin
                page <= I_host_data;
            end
            if (I_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (trigger_wr_c) begin
                            state        <= ST_ALIGN;
                            O_host_ready <= 1'b0;
                            O_dma_busy   <= 1'b1;
                        end
                    end
                    ST_ALIGN: state <= ST_READ;
                    ST_READ: begin
                        data_q <= O_host_data;
                        state  <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        if (count == L_cnt_last) begin
                            count        <= '0;
                            state        <= ST_IDLE;
                            O_host_ready <= 1'b1;
                            O_dma_busy   <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                            state <= ST_READ;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_system_bus.sv
// Self-checking bench: host decode vectors, random host traffic, DMA sequences.
module tb_system_bus;
    import bus_pkg::*;

    localparam int unsigned NS  = 3;
    localparam int unsigned LEN = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [15:0] h_addr;
    logic        h_wren, h_rden;
    logic [7:0]  h_data;
    logic [7:0]  hd_out, hd_out2;
    logic        ready, ready2, busy, busy2;
    logic [15:0] b_addr, b_addr2;
    logic [7:0]  b_data, b_data2;
    logic [2:0]  b_wren, b_rden, b_wren2, b_rden2;
    logic [7:0]  bus_data [NS];
    logic [7:0]  slv_data [NS];
    logic [7:0]  mem0 [256];
    logic        use_mem;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [2:0]  wren;
        logic [2:0]  rden;
    } ev_t;
    ev_t ev [$];
    int  low_ticks, low_clks, stray;

    // Region -> slave as the default map describes it
    int region_slave [8] = '{0, 1, 2, 2, 2, 2, 2, 2};

    always #5 clk = ~clk;

    // Slave models: slave 0 can act as a 256-byte memory
    always_comb begin
        for (int s = 0; s < int'(NS); s++) bus_data[s] = slv_data[s];
        if (use_mem) bus_data[0] = mem0[b_addr[7:0]];
    end

    system_bus dut (
        .I_clock(clk), .I_reset(rst_n), .I_tick(tick),
        .I_host_addr(h_addr), .I_host_wren(h_wren), .I_host_rden(h_rden),
        .I_host_data(h_data), .O_host_data(hd_out), .O_host_ready(ready),
        .O_bus_addr(b_addr), .O_bus_data(b_data), .O_bus_wren(b_wren),
        .O_bus_rden(b_rden), .I_bus_data(bus_data), .O_dma_busy(busy)
    );

    // Second instance whose region 0 maps to nonexistent slave 3
    system_bus #(.P_region_map(16'hAAA7)) dut_unmapped (
        .I_clock(clk), .I_reset(rst_n), .I_tick(tick),
        .I_host_addr(h_addr), .I_host_wren(h_wren), .I_host_rden(h_rden),
        .I_host_data(h_data), .O_host_data(hd_out2), .O_host_ready(ready2),
        .O_bus_addr(b_addr2), .O_bus_data(b_data2), .O_bus_wren(b_wren2),
        .O_bus_rden(b_rden2), .I_bus_data(bus_data), .O_dma_busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, log strobes, then return 1 time unit after posedge
    task automatic cycle(input logic t);
        tick = t;
        @(negedge clk);
        if (|b_wren || |b_rden)
            ev.push_back('{addr: b_addr, data: (|b_rden) ? 8'h00 : b_data, wren: b_wren, rden: b_rden});
        if (!t && busy && (|b_wren || |b_rden)) stray++;
        if (!ready) low_clks++;
        if (!ready && t) low_ticks++;
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [7:0] page);
        h_addr = 16'h4014; h_data = page; h_wren = 1'b1; h_rden = 1'b0; tick = 1'b1;
        @(negedge clk);
        check("trigger_forward_wren", 32'(b_wren), 32'(3'b100));
        check("trigger_forward_data", 32'(b_data), 32'(page));
        @(posedge clk);
        #1;
        h_wren = 1'b0;
        check("trigger_ready_low", 32'(ready), 32'd0);
        check("trigger_busy_high", 32'(busy), 32'd1);
        ev.delete(); low_ticks = 0; low_clks = 0; stray = 0;
    endtask

    task automatic dma_run(input int period, input int inject_at);
        int k;
        k = 0;
        while (!ready && k < 4000) begin
            h_wren = 1'b0; h_rden = 1'b0;
            if (k == inject_at) begin h_addr = 16'h4014; h_data = 8'h77; h_wren = 1'b1; end
            if (k == inject_at + 5) begin h_addr = 16'h0123; h_rden = 1'b1; end
            cycle(((k + 1) % period) == 0);
            k++;
        end
        h_wren = 1'b0; h_rden = 1'b0;
        check("dma_finished", 32'(ready), 32'd1);
        check("dma_busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic check_seq(input logic [7:0] page, input int period);
        ev_t er, ew;
        check("ready_low_ticks", 32'(low_ticks), 32'(1 + 2 * LEN));
        check("ready_low_clocks", 32'(low_clks), 32'((1 + 2 * LEN) * period));
        check("strobe_without_tick", 32'(stray), 32'd0);
        check("seq_length", 32'(ev.size()), 32'(2 * LEN));
        for (int i = 0; i < int'(LEN) && (2 * i + 1) < ev.size(); i++) begin
            er = '{addr: {page, 8'(i)}, data: 8'h00, wren: 3'b000, rden: 3'b001};
            ew = '{addr: 16'h2004, data: mem0[i], wren: 3'b010, rden: 3'b000};
            check($sformatf("dma_read_%0d", i), 32'(ev[2 * i]), 32'(er));
            check($sformatf("dma_write_%0d", i), 32'(ev[2 * i + 1]), 32'(ew));
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr, rd;
        logic [7:0]  wdata;
        logic [7:0]  s0, s1, s2;
        logic [2:0]  ewren, erden;
        logic [7:0]  ehd;
    } vec_t;
    vec_t vecs [7];

    task automatic host_check(input string tag, input logic [15:0] a, input logic w, input logic r,
                              input logic [7:0] d, input logic [2:0] ew, input logic [2:0] er,
                              input logic [7:0] ehd);
        logic [2:0] ew2, er2;
        logic [7:0] ehd2;
        h_addr = a; h_wren = w; h_rden = r; h_data = d; tick = 1'b1;
        ew2 = (a[15:13] == 3'd0) ? 3'b000 : ew;
        er2 = (a[15:13] == 3'd0) ? 3'b000 : er;
        ehd2 = (a[15:13] == 3'd0) ? 8'h00 : ehd;
        @(negedge clk);
        check({tag, "_wren"}, 32'(b_wren), 32'(ew));
        check({tag, "_rden"}, 32'(b_rden), 32'(er));
        check({tag, "_hdata"}, 32'(hd_out), 32'(ehd));
        check({tag, "_addr"}, 32'(b_addr), 32'(a));
        check({tag, "_data"}, 32'(b_data), 32'(d));
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_unmapped_strobes"}, 32'({b_wren2, b_rden2}), 32'({ew2, er2}));
        check({tag, "_unmapped_hdata"}, 32'(hd_out2), 32'(ehd2));
        @(posedge clk);
        #1;
        h_wren = 1'b0; h_rden = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic        w, r;
        logic [7:0]  d;
        int          sl;
        logic [2:0]  oh;

        rst_n = 1'b0; tick = 1'b0; h_addr = '0; h_wren = 1'b0; h_rden = 1'b0; h_data = '0;
        use_mem = 1'b0;
        for (int s = 0; s < int'(NS); s++) slv_data[s] = 8'h00;
        for (int i = 0; i < 256; i++) mem0[i] = 8'($urandom);
        low_ticks = 0; low_clks = 0; stray = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobes", 32'({b_wren, b_rden}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed host-path vectors
        vecs[0] = '{16'h0123, 1'b0, 1'b1, 8'h00, 8'hA5, 8'h11, 8'h22, 3'b000, 3'b001, 8'hA5};
        vecs[1] = '{16'h6000, 1'b1, 1'b0, 8'h3C, 8'h10, 8'h20, 8'h30, 3'b100, 3'b000, 8'h30};
        vecs[2] = '{16'h2004, 1'b0, 1'b1, 8'h00, 8'h01, 8'h5E, 8'h03, 3'b000, 3'b010, 8'h5E};
        vecs[3] = '{16'hFFFF, 1'b0, 1'b1, 8'h00, 8'h01, 8'h02, 8'hC3, 3'b000, 3'b100, 8'hC3};
        vecs[4] = '{16'h1FFF, 1'b1, 1'b0, 8'h99, 8'h44, 8'h55, 8'h66, 3'b001, 3'b000, 8'h44};
        vecs[5] = '{16'h3FFF, 1'b0, 1'b1, 8'h00, 8'h44, 8'h7E, 8'h66, 3'b000, 3'b010, 8'h7E};
        vecs[6] = '{16'h4000, 1'b0, 1'b0, 8'h12, 8'h44, 8'h55, 8'hE1, 3'b000, 3'b000, 8'hE1};
        for (int v = 0; v < 7; v++) begin
            slv_data[0] = vecs[v].s0; slv_data[1] = vecs[v].s1; slv_data[2] = vecs[v].s2;
            host_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].wr, vecs[v].rd,
                       vecs[v].wdata, vecs[v].ewren, vecs[v].erden, vecs[v].ehd);
        end

        // Random host traffic against the region table
        for (int n = 0; n < 30; n++) begin
            a = 16'($urandom);
            w = 1'($urandom);
            r = w ? 1'b0 : 1'($urandom);
            d = 8'($urandom);
            if (a == 16'h4014) a = 16'h4015;
            for (int s = 0; s < int'(NS); s++) slv_data[s] = 8'($urandom);
            sl = region_slave[a[15:13]];
            oh = 3'(1 << sl);
            host_check($sformatf("rnd%0d", n), a, w, r, d, w ? oh : 3'b000, r ? oh : 3'b000,
                       slv_data[sl]);
        end

        // Full DMA, continuous ticks
        use_mem = 1'b1;
        trigger(8'h02);
        dma_run(1, -100);
        check_seq(8'h02, 1);

        // Full DMA, tick every third clock
        repeat (2) cycle(1'b1);
        trigger(8'h02);
        dma_run(3, -100);
        check_seq(8'h02, 3);

        // Trigger and host read during DMA are ignored
        repeat (2) cycle(1'b1);
        trigger(8'h01);
        dma_run(1, 40);
        check_seq(8'h01, 1);

        // Reset in the middle of a transfer
        repeat (2) cycle(1'b1);
        trigger(8'h03);
        for (int k = 0; k < 100 && ev.size() < 20; k++) cycle(1'b1);
        check("pre_reset_events", 32'(ev.size()), 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_strobes", 32'({b_wren, b_rden}), 32'd0);
        @(posedge clk);
        #1;
        ev.delete();
        repeat (3) cycle(1'b1);
        rst_n = 1'b1;
        repeat (3) cycle(1'b1);
        check("post_abort_events", 32'(ev.size()), 32'd0);
        trigger(8'h02);
        dma_run(1, -100);
        check_seq(8'h02, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
